snn_fc_sequencer: RTL and testbench
===================================

# snn_fc_sequencer

Control sequencer for the 28×10 fully-connected spiking layer. It steps the weight, input and bias BRAMs row by row and gates the 10-neuron accumulator. Each timestep it strobes neuron update and state write-back, and after `T_STEPS` timesteps it reports the winning output class from per-neuron spike counts. It replaces the free-running load/count generator and address generator pair, and owns all enables of the FC datapath.

## Interface
- `ROWS`, 28, input rows per image; one BRAM word per row.
- `N_OUT`, 10, output neurons.
- `T_STEPS`, 20, simulation timesteps per image.
- `LOAD_CYC`, 2, cycles `en_load` is held per row (BRAM read latency).
- `ACC_CYC`, 3, settle/accumulate cycles per row.
- `CNT_W`, 8, spike counter width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request an image run; sampled only in IDLE.
- `spike_in` in `N_OUT`: fired spikes from the neuron activation; valid in WB.
- `busy` out 1: high from the cycle after `start` is accepted through DONE inclusive.
- `en_load` out 1: BRAM read enable; high in LOAD.
- `addr_r` out 6: row address for x, weight and old-state BRAMs.
- `acc_clr` out 1: clear the `v_fc_sum` accumulator.
- `acc_en` out 1: add `v_in` into the accumulator.
- `bias_en` out 1: also add bias; asserted together with `acc_en` on the last row only.
- `first_step` out 1: high for all of timestep 0; datapath masks old V/spike with `!first_step`.
- `fire_en` out 1: neuron update strobe.
- `wr_en` out 1: V/spike state write strobe.
- `clr_state` out 1: zero V/spike state memory.
- `done` out 1: one-cycle completion pulse.
- `class_out` out 4: winning neuron index.

## Operation
- States: IDLE, LOAD, ACC, FIRE, WB, DONE.
- IDLE with `start=1`:
  - go to LOAD; row=0, step=0.
  - clear all spike counters.
- LOAD: `en_load=1`, `addr_r=row`, stay `LOAD_CYC` cycles.
  - `acc_clr=1` on the first LOAD cycle of row 0 of every timestep.
- ACC: stay `ACC_CYC` cycles; `addr_r` holds row.
  - `acc_en=1` on the final ACC cycle only.
  - `bias_en=1` on that same cycle when row=`ROWS-1`.
  - Then, if row<`ROWS-1`: row+1, go to LOAD; otherwise go to FIRE.
- FIRE: `fire_en=1` for 1 cycle.
- WB: `wr_en=1` for 1 cycle.
  - Counter[i] += `spike_in[i]`, saturating at 2^`CNT_W`−1.
  - If step<`T_STEPS-1`: step+1, row=0, go to LOAD; otherwise go to DONE.
- DONE: for 1 cycle, `done=1` and `clr_state=1`.
  - `class_out` is registered as the argmax of the counters; ties go to the lowest index; all-zero counts give 0.
  - Next state is IDLE.
- `first_step` = (step==0) in LOAD/ACC/FIRE/WB; 0 otherwise.
- `start` while busy: ignored. `start` held high in IDLE after DONE: starts a new run.
- `spike_in` is ignored outside WB.
- `addr_r` is 0 in IDLE, FIRE, WB and DONE.

## Timing
- Reset values: state IDLE. All outputs 0, including `class_out`. Counters, row and step are 0.
- Reset mid-run: return to IDLE next cycle. No `done`, no `clr_state`. Stale state memory is harmless because the next run's step 0 masks it via `first_step`.
- `class_out` holds its value until the next DONE.
- Cycles per timestep: P = `ROWS`·(`LOAD_CYC`+`ACC_CYC`)+2. With defaults, P=142.
- `start` accepted at cycle 0 (defaults):
  - Row r LOAD at cycles 1+5r..2+5r.
  - Row r `acc_en` at cycle 5+5r; row 27 at cycle 140 with `bias_en`.
  - FIRE at 141, WB at 142, step 1 LOAD at 143.
  - WB of the last step at `T_STEPS`·142.
  - DONE/`done` at `T_STEPS`·142+1 = 2841.
  - IDLE at 2842; `busy` is low from cycle 2842.
- Earliest restart: `start` at 2842 is accepted, with LOAD at 2843.

## Test plan
- Reset, then `start` pulse at cycle 0 → `en_load` high at cycles 1–2 with `addr_r`=0, and at cycles 6–7 with `addr_r`=1. `acc_en` at cycles 5, 10, …, 140; `bias_en` only at 140. `acc_clr` only at 1, 143, 285, ….
- `first_step` is 1 over cycles 1–142 and 0 from 143. `fire_en`/`wr_en` at 141/142, 283/284, …. `done` and `clr_state` at 2841; `busy` low at 2842.
- `spike_in`=10'b0000001000 in every WB, plus neuron 1 firing in 5 steps → `class_out`=3. Ties between neurons 2 and 7 (count 4 each, others 0) → `class_out`=2. No spikes → 0.
- `T_STEPS`=300 with `CNT_W`=8, neuron 9 firing every step → its counter saturates at 255, no wrap, `class_out`=9.
- `start` pulsed at cycle 500 mid-run → ignored; timing is unchanged and there is exactly one `done`.
- `rst` asserted at cycle 700 → next cycle all outputs are 0 and the state is IDLE. A new `start` at 710 gives `acc_clr` and `en_load` at 711, and `done` at 710+2841.

Source files
------------

// File: rtl/snn_fc_sequencer.sv
// ---------------------------------------------------------------------------
// snn_fc_sequencer
//   Control sequencer for the fully-connected spiking layer. For every
//   timestep it walks the input rows (BRAM load, then settle/accumulate),
//   strobes the neuron update and the V/spike write-back, and counts output
//   spikes per neuron. After T_STEPS timesteps it reports the argmax neuron.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   start      : run request, sampled only while idle
//   spike_in   : neuron spikes, consumed during write-back only
//   busy       : run in progress (LOAD .. DONE)
//   en_load    : BRAM read enable
//   addr_r     : row address for x / weight / old-state BRAMs
//   acc_clr    : clear the row accumulator (first load cycle of each timestep)
//   acc_en     : accumulate the current row
//   bias_en    : add bias as well (last row only)
//   first_step : timestep 0 marker; datapath masks stale V/spike state
//   fire_en    : neuron update strobe
//   wr_en      : V/spike state write strobe
//   clr_state  : zero the V/spike state memory
//   done       : one-cycle completion pulse
//   class_out  : winning neuron index, held until the next completion
// ---------------------------------------------------------------------------
module snn_fc_sequencer #(
   parameter int ROWS     = 28,
   parameter int N_OUT    = 10,
   parameter int T_STEPS  = 20,
   parameter int LOAD_CYC = 2,
   parameter int ACC_CYC  = 3,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [N_OUT-1:0] spike_in,
   output logic             busy,
   output logic             en_load,
   output logic [5:0]       addr_r,
   output logic             acc_clr,
   output logic             acc_en,
   output logic             bias_en,
   output logic             first_step,
   output logic             fire_en,
   output logic             wr_en,
   output logic             clr_state,
   output logic             done,
   output logic [3:0]       class_out
);

   localparam int STEP_W  = (T_STEPS > 1) ? $clog2(T_STEPS) : 1;
   localparam int SUB_MAX = (LOAD_CYC > ACC_CYC) ? LOAD_CYC : ACC_CYC;
   localparam int SUB_W   = (SUB_MAX > 1) ? $clog2(SUB_MAX) : 1;

   localparam logic [5:0]        LAST_ROW  = 6'(ROWS - 1);
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(T_STEPS - 1);
   localparam logic [SUB_W-1:0]  LOAD_LAST = SUB_W'(LOAD_CYC - 1);
   localparam logic [SUB_W-1:0]  ACC_LAST  = SUB_W'(ACC_CYC - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_ACC, S_FIRE, S_WB, S_DONE
   } state_e;

   state_e            state_q, state_d;
   logic [SUB_W-1:0]  cyc_q, cyc_d;    // cycle index inside LOAD / ACC
   logic [5:0]        row_q, row_d;
   logic [STEP_W-1:0] step_q, step_d;

   logic [CNT_W-1:0]  cnt_q [N_OUT];
   logic [3:0]        class_q;
   logic [3:0]        best_idx;
   logic [CNT_W-1:0]  best_val;

   // -------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cyc_q   <= '0;
         row_q   <= '0;
         step_q  <= '0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         row_q   <= row_d;
         step_q  <= step_d;
      end
   end

   // -------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------
   // NOTE: every variable gets a default before the case so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      row_d   = row_q;
      step_d  = step_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LOAD;
               cyc_d   = '0;
               row_d   = '0;
               step_d  = '0;
            end
         end
         S_LOAD: begin
            if (cyc_q == LOAD_LAST) begin
               state_d = S_ACC;
               cyc_d   = '0;
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
         S_ACC: begin
            if (cyc_q == ACC_LAST) begin
               cyc_d = '0;
               if (row_q < LAST_ROW) begin
                  row_d   = row_q + 6'd1;
                  state_d = S_LOAD;
               end else begin
                  row_d   = '0;
                  state_d = S_FIRE;
               end
            end else begin
               cyc_d = cyc_q + 1'b1;
            end
         end
         S_FIRE: state_d = S_WB;
         S_WB: begin
            row_d = '0;
            if (step_q < LAST_STEP) begin
               step_d  = step_q + 1'b1;
               state_d = S_LOAD;
            end else begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            step_d  = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // -------------------------------------------------------------------
   // Output decode (Moore; only class_out is registered)
   // -------------------------------------------------------------------
   always_comb begin
      busy       = (state_q != S_IDLE);
      en_load    = 1'b0;
      addr_r     = '0;
      acc_clr    = 1'b0;
      acc_en     = 1'b0;
      bias_en    = 1'b0;
      first_step = 1'b0;
      fire_en    = 1'b0;
      wr_en      = 1'b0;
      clr_state  = 1'b0;
      done       = 1'b0;
      class_out  = class_q;
      unique case (state_q)
         S_LOAD: begin
            en_load    = 1'b1;
            addr_r     = row_q;
            acc_clr    = (cyc_q == '0) && (row_q == '0);
            first_step = (step_q == '0);
         end
         S_ACC: begin
            addr_r     = row_q;
            acc_en     = (cyc_q == ACC_LAST);
            bias_en    = (cyc_q == ACC_LAST) && (row_q == LAST_ROW);
            first_step = (step_q == '0);
         end
         S_FIRE: begin
            fire_en    = 1'b1;
            first_step = (step_q == '0);
         end
         S_WB: begin
            wr_en      = 1'b1;
            first_step = (step_q == '0);
         end
         S_DONE: begin
            done      = 1'b1;
            clr_state = 1'b1;
         end
         default: ;
      endcase
   end

   // -------------------------------------------------------------------
   // Argmax: strict '>' keeps the lowest index on ties; all-zero gives 0
   // -------------------------------------------------------------------
   always_comb begin
      best_idx = '0;
      best_val = cnt_q[0];
      for (int i = 1; i < N_OUT; i++) begin
         if (cnt_q[i] > best_val) begin
            best_val = cnt_q[i];
            best_idx = 4'(i);
         end
      end
   end

   // -------------------------------------------------------------------
   // Spike counters and result register
   // -------------------------------------------------------------------
   // NOTE: the counters are a small register array rather than a RAM, so
   // they take the synchronous reset like any other flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_OUT; i++) cnt_q[i] <= '0;
         class_q <= '0;
      end else begin
         if (state_q == S_IDLE && start) begin
            for (int i = 0; i < N_OUT; i++) cnt_q[i] <= '0;
         end else if (state_q == S_WB) begin
            for (int i = 0; i < N_OUT; i++) begin
               if (spike_in[i] && cnt_q[i] != CNT_MAX) cnt_q[i] <= cnt_q[i] + 1'b1;
            end
         end
         if (state_q == S_DONE) class_q <= best_idx;
      end
   end

endmodule

// File: tb/tb_snn_fc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_snn_fc_sequencer
//   Directed bench for snn_fc_sequencer. A table of hand-computed output
//   vectors pins the documented cycle positions of the first run; every
//   cycle of each run is also compared against the closed-form schedule
//   (period 142 = 28 rows x 5 cycles + FIRE + WB). A second instance with
//   300 timesteps exercises counter saturation.
// ---------------------------------------------------------------------------
module tb_snn_fc_sequencer;

   localparam int ROWS  = 28;
   localparam int RC    = 5;                 // LOAD_CYC + ACC_CYC
   localparam int P     = ROWS * RC + 2;     // 142
   localparam int T     = 20;
   localparam int LAST  = T * P + 1;         // 2841, DONE cycle
   localparam int T2    = 300;
   localparam int LAST2 = T2 * P + 1;        // 42601

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [9:0] spike_in;
   logic       busy, en_load, acc_clr, acc_en, bias_en, first_step;
   logic       fire_en, wr_en, clr_state, done;
   logic [5:0] addr_r;
   logic [3:0] class_out;

   logic       start2;
   logic [9:0] spike2;
   logic       busy2, en_load2, acc_clr2, acc_en2, bias_en2, first_step2;
   logic       fire_en2, wr_en2, clr_state2, done2;
   logic [5:0] addr_r2;
   logic [3:0] class_out2;

   always #5 clk = ~clk;

   snn_fc_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .spike_in(spike_in),
      .busy(busy), .en_load(en_load), .addr_r(addr_r), .acc_clr(acc_clr),
      .acc_en(acc_en), .bias_en(bias_en), .first_step(first_step),
      .fire_en(fire_en), .wr_en(wr_en), .clr_state(clr_state),
      .done(done), .class_out(class_out)
   );

   snn_fc_sequencer #(.T_STEPS(T2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .spike_in(spike2),
      .busy(busy2), .en_load(en_load2), .addr_r(addr_r2), .acc_clr(acc_clr2),
      .acc_en(acc_en2), .bias_en(bias_en2), .first_step(first_step2),
      .fire_en(fire_en2), .wr_en(wr_en2), .clr_state(clr_state2),
      .done(done2), .class_out(class_out2)
   );

   typedef struct {
      int          cyc;
      logic [15:0] exp;
   } vec_t;

   int          checks = 0;
   int          errors = 0;
   int          done_seen;
   logic [15:0] trace [0:LAST];
   vec_t        tbl [16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // {busy, en_load, addr_r, acc_clr, acc_en, bias_en, first_step, fire_en, wr_en, clr_state, done}
   function automatic logic [15:0] mk(logic b, logic l, int a, logic ac, logic ae, logic be,
                                      logic fs, logic fe, logic we, logic cs, logic dn);
      return {b, l, 6'(a), ac, ae, be, fs, fe, we, cs, dn};
   endfunction

   function automatic logic [15:0] dut_vec();
      return {busy, en_load, addr_r, acc_clr, acc_en, bias_en, first_step,
              fire_en, wr_en, clr_state, done};
   endfunction

   // Expected outputs at cycle c of a run whose start was accepted at cycle 0.
   function automatic logic [15:0] exp_vec(int c, int last);
      int off, s, row, sub;
      if (c <= 0 || c > last) return '0;
      if (c == last) return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      off = (c - 1) % P;
      s   = (c - 1) / P;
      if (off < ROWS * RC) begin
         row = off / RC;
         sub = off % RC;
         return mk(1, sub < 2, row, off == 0, sub == 4, (sub == 4) && (row == ROWS - 1),
                   s == 0, 0, 0, 0, 0);
      end
      if (off == P - 2) return mk(1, 0, 0, 0, 0, 0, s == 0, 1, 0, 0, 0);
      return mk(1, 0, 0, 0, 0, 0, s == 0, 0, 1, 0, 0);
   endfunction

   // Spike stimulus: pattern value during WB, distractor value elsewhere.
   function automatic logic [9:0] spike_for(int pat, int c, int last);
      logic       in_wb;
      int         s;
      logic [9:0] v;
      in_wb = 1'b0;
      s     = 0;
      if (c >= 1 && c < last) begin
         in_wb = ((c - 1) % P) == P - 1;
         s     = (c - 1) / P;
      end
      v = '0;
      case (pat)
         0: begin
            if (in_wb) begin
               v = 10'h008;
               if (s < 5) v = v | 10'h002;
            end else v = 10'h3FF;
         end
         1: begin
            if (in_wb) begin
               if (s < 4) v = v | 10'h004;
               if (s >= 10 && s < 14) v = v | 10'h080;
            end
         end
         2: if (!in_wb) v = 10'h200;
         default: begin
            if (in_wb) begin
               v = 10'h200;
               if (s < 100) v = v | 10'h001;
            end
         end
      endcase
      return v;
   endfunction

   // One image run on dut: cycle 0 is the IDLE cycle in which start is driven.
   task automatic run_image(input int pat, input logic hold, input logic mid_start,
                            input int abort_at, input logic [3:0] prev_class, input logic record);
      done_seen = 0;
      for (int c = 0; c <= LAST; c++) begin
         tick();
         if (abort_at > 0 && c == abort_at) rst = 1'b1;
         start    = (c == 0) || hold || (mid_start && c == 500);
         spike_in = spike_for(pat, c, LAST);
         check($sformatf("vec p%0d c%0d", pat, c), 32'(dut_vec()), 32'(exp_vec(c, LAST)));
         check($sformatf("class_hold p%0d c%0d", pat, c), 32'(class_out), 32'(prev_class));
         if (record) trace[c] = dut_vec();
         if (done) done_seen++;
         if (abort_at > 0 && c == abort_at) return;
      end
      check($sformatf("done_count p%0d", pat), 32'(done_seen), 32'd1);
   endtask

   task automatic idle_check(input string name, input logic [3:0] exp_class);
      tick();
      start    = 1'b0;
      spike_in = '0;
      check({name, " vec"}, 32'(dut_vec()), 32'd0);
      check({name, " class"}, 32'(class_out), 32'(exp_class));
   endtask

   initial begin
      int done_cyc;
      int done_cnt2;

      tbl[0]  = '{0,    mk(0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0)};
      tbl[1]  = '{1,    mk(1, 1, 0,  1, 0, 0, 1, 0, 0, 0, 0)};
      tbl[2]  = '{2,    mk(1, 1, 0,  0, 0, 0, 1, 0, 0, 0, 0)};
      tbl[3]  = '{5,    mk(1, 0, 0,  0, 1, 0, 1, 0, 0, 0, 0)};
      tbl[4]  = '{6,    mk(1, 1, 1,  0, 0, 0, 1, 0, 0, 0, 0)};
      tbl[5]  = '{7,    mk(1, 1, 1,  0, 0, 0, 1, 0, 0, 0, 0)};
      tbl[6]  = '{10,   mk(1, 0, 1,  0, 1, 0, 1, 0, 0, 0, 0)};
      tbl[7]  = '{140,  mk(1, 0, 27, 0, 1, 1, 1, 0, 0, 0, 0)};
      tbl[8]  = '{141,  mk(1, 0, 0,  0, 0, 0, 1, 1, 0, 0, 0)};
      tbl[9]  = '{142,  mk(1, 0, 0,  0, 0, 0, 1, 0, 1, 0, 0)};
      tbl[10] = '{143,  mk(1, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0)};
      tbl[11] = '{283,  mk(1, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0)};
      tbl[12] = '{284,  mk(1, 0, 0,  0, 0, 0, 0, 0, 1, 0, 0)};
      tbl[13] = '{285,  mk(1, 1, 0,  1, 0, 0, 0, 0, 0, 0, 0)};
      tbl[14] = '{2840, mk(1, 0, 0,  0, 0, 0, 0, 0, 1, 0, 0)};
      tbl[15] = '{2841, mk(1, 0, 0,  0, 0, 0, 0, 0, 0, 1, 1)};

      rst      = 1'b1;
      start    = 1'b0;
      spike_in = '0;
      start2   = 1'b0;
      spike2   = '0;
      repeat (3) tick();
      check("reset vec", 32'(dut_vec()), 32'd0);
      check("reset class", 32'(class_out), 32'd0);
      check("reset busy2", 32'(busy2), 32'd0);
      rst = 1'b0;

      // Run A: neuron 3 every step, neuron 1 in 5 steps, distractors outside
      // WB, extra start at cycle 500 -> class 3.
      run_image(0, 1'b0, 1'b1, 0, 4'd0, 1'b1);
      for (int i = 0; i < 16; i++)
         check($sformatf("table c%0d", tbl[i].cyc), 32'(trace[tbl[i].cyc]), 32'(tbl[i].exp));
      idle_check("runA end", 4'd3);

      // Mid-run reset at relative cycle 700.
      run_image(0, 1'b0, 1'b0, 700, 4'd3, 1'b0);
      tick();
      rst = 1'b0;
      start = 1'b0;
      check("post_rst vec", 32'(dut_vec()), 32'd0);
      check("post_rst class", 32'(class_out), 32'd0);
      check("post_rst no_done", 32'(done_seen), 32'd0);
      for (int c = 702; c <= 709; c++) begin
         tick();
         check($sformatf("idle c%0d", c), 32'(dut_vec()), 32'd0);
      end

      // Run B at 710: tie between neurons 2 and 7 -> class 2; start held
      // high so run C is accepted in the IDLE cycle right after DONE.
      run_image(1, 1'b1, 1'b0, 0, 4'd0, 1'b0);
      // Run C: no spikes during WB -> class 0.
      run_image(2, 1'b0, 1'b0, 0, 4'd2, 1'b0);
      idle_check("runC end", 4'd0);

      // Saturation: 300 steps, neuron 9 every step (255), neuron 0 in 100.
      done_cyc  = -1;
      done_cnt2 = 0;
      for (int c = 0; c <= LAST2 + 1; c++) begin
         tick();
         start2 = (c == 0);
         spike2 = spike_for(3, c, LAST2);
         if (done2) begin
            done_cnt2++;
            done_cyc = c;
         end
         if (c == LAST2 + 1) begin
            check("sat class", 32'(class_out2), 32'd9);
            check("sat busy_low", 32'(busy2), 32'd0);
         end
      end
      check("sat done_cycle", 32'(done_cyc), 32'(LAST2));
      check("sat done_count", 32'(done_cnt2), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
